in_conditioner: RTL

//  Input-port conditioner upstream of the microcontroller's 32-bit 'in' bus (4 ports x 8 bits).

---
 rtl/debounce_bit.sv | 68 ++++++
 rtl/in_conditioner.sv | 104 ++++++++++
 2 files changed

// File: rtl/debounce_bit.sv
// Single-bit conditioner: 2-flop synchroniser, stability counter and debounced level flop.
module debounce_bit #(
    parameter int unsigned STABLE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic s_in,
    output logic deb
);

    // Ceiling log2, used only to size the stability counter.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned CW_RAW = clog2(STABLE + 1);
    localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;

    logic          meta_q, meta_d;
    logic          s_q,    s_d;
    logic          deb_q,  deb_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    // Next state: sync chain always shifts; the counter and level move only on a sample tick.
    always_comb begin
        meta_d = s_in;
        s_d    = meta_q;
        deb_d  = deb_q;
        cnt_d  = cnt_q;
        if (tick) begin
            if (s_q == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q + CW'(1) == CW'(STABLE)) begin
                deb_d = s_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            s_q    <= 1'b0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            s_q    <= s_d;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/in_conditioner.sv
// Input-port conditioner: synchronise and debounce 4x8 pins, optionally as sticky rising-edge flags.
module in_conditioner #(
    parameter int unsigned PRESC     = 1000,
    parameter int unsigned STABLE    = 4,
    parameter logic [3:0]  EDGE_MASK = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pin,
    input  logic [3:0]  rd_clr,
    output logic [31:0] q,
    output logic [3:0]  evt,
    output logic        tick
);

    // Ceiling log2, used only to size the prescaler.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned PORTS  = 4;
    localparam int unsigned PORT_W = 8;
    localparam int unsigned NBITS  = PORTS * PORT_W;
    localparam int unsigned PW_RAW = clog2(PRESC);
    localparam int unsigned PW     = (PW_RAW < 1) ? 1 : PW_RAW;

    logic [PW-1:0]    pre_q,      pre_d;
    logic             tick_q,     tick_d;
    logic [NBITS-1:0] deb_prev_q, deb_prev_d;
    logic [NBITS-1:0] flag_q,     flag_d;
    logic [NBITS-1:0] deb;
    logic [NBITS-1:0] rise_c;
    logic [NBITS-1:0] clr_mask_c;
    logic [NBITS-1:0] flag_vis_c;

    // One debouncer per pin bit.
    for (genvar i = 0; i < NBITS; i++) begin : g_bit
        debounce_bit #(.STABLE(STABLE)) u_deb (
            .clk  (clk),
            .reset(reset),
            .tick (tick),
            .s_in (pin[i]),
            .deb  (deb[i])
        );
    end

    // Prescaler wraps at PRESC-1; tick is registered high while the count sits at PRESC-1.
    always_comb begin
        pre_d  = (pre_q == PW'(PRESC - 1)) ? '0 : pre_q + PW'(1);
        tick_d = (pre_d == PW'(PRESC - 1));
    end

    // Edge flags: a rise seen this cycle is presented at once and always survives a same-cycle clear.
    always_comb begin
        rise_c     = deb & ~deb_prev_q;
        clr_mask_c = '0;
        for (int p = 0; p < PORTS; p++) begin
            clr_mask_c[PORT_W*p +: PORT_W] = {PORT_W{rd_clr[p]}};
        end
        flag_d     = (flag_q & ~clr_mask_c) | rise_c;
        deb_prev_d = deb;
        flag_vis_c = flag_q | rise_c;
    end

    // Output mux: per port, either debounced levels or edge flags.
    always_comb begin
        q   = '0;
        evt = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (EDGE_MASK[p]) begin
                q[PORT_W*p +: PORT_W] = flag_vis_c[PORT_W*p +: PORT_W];
                evt[p]                = |flag_vis_c[PORT_W*p +: PORT_W];
            end else begin
                q[PORT_W*p +: PORT_W] = deb[PORT_W*p +: PORT_W];
            end
        end
    end

    // Top-level state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q      <= '0;
            tick_q     <= 1'b0;
            deb_prev_q <= '0;
            flag_q     <= '0;
        end else begin
            pre_q      <= pre_d;
            tick_q     <= tick_d;
            deb_prev_q <= deb_prev_d;
            flag_q     <= flag_d;
        end
    end

    assign tick = tick_q;

endmodule
